// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor path.
package dma_pkg;

    // Error report codes carried on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;

    // AXI burst type encodings; RSVD is never legal
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Field widths of the stored descriptor; the queue's ID/address
    // parameters are expected to match these.
    localparam int DMA_ID_WD   = 2;
    localparam int DMA_ADDR_WD = 16;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BACKOFF
    } issue_state_e;

    // One transfer descriptor as it sits in the queue
    typedef struct packed {
        logic [DMA_ADDR_WD-1:0] addr;
        logic [DMA_ID_WD-1:0]   id;
        logic [1:0]             burst;
        logic [2:0]             size;
        logic [DMA_ADDR_WD-1:0] len;
    } dma_desc_t;

    // A descriptor is legal when it moves data, uses a defined burst
    // type and does not ask for beats wider than the data bus.
    function automatic logic desc_is_legal(input dma_desc_t d, input logic [2:0] max_size);
        return (d.len != '0) && (d.burst != BURST_RSVD) && (d.size <= max_size);
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous circular-buffer FIFO with registered occupancy.
module dma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty differ
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    // Advance pointers and track occupancy; simultaneous push/pop keeps level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dma_cmd_queue.sv
// Descriptor legality check, queueing and retrying issue stage for axi_top.
module dma_cmd_queue
    import dma_pkg::*;
#(
    parameter int AXI_ID_WD   = DMA_ID_WD,
    parameter int AXI_DATA_WD = 32,
    parameter int AXI_ADDR_WD = DMA_ADDR_WD,
    parameter int DEPTH       = 4,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF_CYC = 8
) (
    input  logic                     AXI_ACLK,
    input  logic                     AXI_ARESET,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic [AXI_ADDR_WD-1:0]   desc_addr,
    input  logic [AXI_ID_WD-1:0]     desc_id,
    input  logic [1:0]               desc_burst,
    input  logic [2:0]               desc_size,
    input  logic [AXI_ADDR_WD-1:0]   desc_len,
    output logic                     cmd_valid,
    output logic [AXI_ADDR_WD-1:0]   cmd_addr,
    output logic [AXI_ID_WD-1:0]     cmd_id,
    output logic [1:0]               cmd_burst,
    output logic [2:0]               cmd_size,
    output logic [AXI_ADDR_WD-1:0]   cmd_len,
    input  logic                     cmd_ready,
    input  logic                     cmd_abort,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic [AXI_ID_WD-1:0]     err_id,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DATA_WD/8));
    localparam int RW = $clog2(MAX_RETRY+1);
    localparam int BW = $clog2(BACKOFF_CYC+1);

    dma_desc_t            desc_in, fifo_head;
    logic                 fifo_full, fifo_empty;
    logic                 desc_legal, desc_take, fifo_push, fifo_pop;
    logic                 illegal_evt, exhaust_evt, in_issue, retry_done;
    logic [8:0]           drop_sum;

    issue_state_e         state_q, state_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [BW-1:0]        backoff_q, backoff_d;
    dma_desc_t            cmd_q, cmd_d;
    logic                 err_valid_q, err_valid_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [AXI_ID_WD-1:0] err_id_q, err_id_d;
    logic                 pend_q, pend_d;
    logic [AXI_ID_WD-1:0] pend_id_q, pend_id_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    assign desc_in     = '{addr: desc_addr, id: desc_id, burst: desc_burst, size: desc_size, len: desc_len};
    assign desc_legal  = desc_is_legal(desc_in, MAX_SIZE);
    assign desc_ready  = !fifo_full && !pend_q;
    assign desc_take   = desc_valid && desc_ready;
    assign fifo_push   = desc_take && desc_legal;
    assign illegal_evt = desc_take && !desc_legal;
    assign in_issue    = (state_q == ST_ISSUE);
    assign retry_done  = (retry_q == RW'(MAX_RETRY));
    assign exhaust_evt = in_issue && !cmd_ready && cmd_abort && retry_done;
    assign fifo_pop    = in_issue && (cmd_ready || exhaust_evt);

    dma_sync_fifo #(
        .WIDTH ($bits(dma_desc_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (AXI_ACLK),
        .rst   (AXI_ARESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (desc_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Issue FSM: load head, offer it, back off and retry on abort
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        backoff_d = backoff_q;
        cmd_d     = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cmd_d   = fifo_head;
                    retry_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end else if (cmd_abort) begin
                    if (retry_done) begin
                        state_d = ST_IDLE;
                    end else begin
                        retry_d   = retry_q + RW'(1);
                        backoff_d = BW'(BACKOFF_CYC);
                        state_d   = ST_BACKOFF;
                    end
                end
            end
            ST_BACKOFF: begin
                if (backoff_q == BW'(1)) state_d = ST_ISSUE;
                else                     backoff_d = backoff_q - BW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error reporting: an exhaust drop wins, a colliding illegal report waits one cycle
    always_comb begin
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        err_id_d    = '0;
        pend_d      = pend_q;
        pend_id_d   = pend_id_q;
        if (exhaust_evt) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_RETRY;
            err_id_d    = cmd_q.id;
            if (illegal_evt) begin
                pend_d    = 1'b1;
                pend_id_d = desc_id;
            end
        end else if (pend_q) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_ILLEGAL;
            err_id_d    = pend_id_q;
            pend_d      = 1'b0;
        end else if (illegal_evt) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_ILLEGAL;
            err_id_d    = desc_id;
        end
        drop_sum   = {1'b0, drop_cnt_q} + {8'd0, exhaust_evt} + {8'd0, illegal_evt};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // State registers; reset discards everything without reporting
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q     <= ST_IDLE;
            retry_q     <= '0;
            backoff_q   <= '0;
            cmd_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_id_q    <= '0;
            pend_q      <= 1'b0;
            pend_id_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            backoff_q   <= backoff_d;
            cmd_q       <= cmd_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_id_q    <= err_id_d;
            pend_q      <= pend_d;
            pend_id_q   <= pend_id_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign cmd_valid = in_issue;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_id    = cmd_q.id;
    assign cmd_burst = cmd_q.burst;
    assign cmd_size  = cmd_q.size;
    assign cmd_len   = cmd_q.len;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_id    = err_id_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed, scoreboard-based testbench for dma_cmd_queue.
module tb_dma_cmd_queue;
    import dma_pkg::*;

    typedef struct packed {
        logic [1:0] code;
        logic [1:0] id;
    } err_exp_t;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_ARESET;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_addr;
    logic [1:0]  desc_id;
    logic [1:0]  desc_burst;
    logic [2:0]  desc_size;
    logic [15:0] desc_len;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [1:0]  cmd_id;
    logic [1:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic [15:0] cmd_len;
    logic        cmd_ready;
    logic        cmd_abort;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [1:0]  err_id;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          exp_drop = 0;
    dma_desc_t   exp_cmd[$];
    err_exp_t    exp_err[$];
    int          hs_cycles[$];
    dma_desc_t   mon_cmd;
    err_exp_t    mon_err;

    dma_cmd_queue dut (
        .AXI_ACLK   (AXI_ACLK),
        .AXI_ARESET (AXI_ARESET),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_id    (desc_id),
        .desc_burst (desc_burst),
        .desc_size  (desc_size),
        .desc_len   (desc_len),
        .cmd_valid  (cmd_valid),
        .cmd_addr   (cmd_addr),
        .cmd_id     (cmd_id),
        .cmd_burst  (cmd_burst),
        .cmd_size   (cmd_size),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .cmd_abort  (cmd_abort),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_id     (err_id),
        .level      (level),
        .drop_cnt   (drop_cnt)
    );

    // Free-running clock and cycle counter
    always #5 AXI_ACLK = ~AXI_ACLK;
    always @(posedge AXI_ACLK) cyc <= cyc + 1;

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge AXI_ACLK);
        #1;
    endtask

    // Offer one descriptor until accepted, recording what the DUT should do with it
    task automatic applyStimulus(input logic [15:0] addr, input logic [1:0] id,
                                 input logic [1:0] burst, input logic [2:0] size,
                                 input logic [15:0] len);
        int  waited;
        logic legal;
        desc_addr  = addr;
        desc_id    = id;
        desc_burst = burst;
        desc_size  = size;
        desc_len   = len;
        desc_valid = 1'b1;
        waited     = 0;
        while (desc_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("desc_accept", desc_ready, 1'b1);
        legal = (len != 16'd0) && (burst != 2'b11) && (size <= 3'd2);
        if (legal) begin
            exp_cmd.push_back('{addr: addr, id: id, burst: burst, size: size, len: len});
        end else begin
            exp_err.push_back('{code: 2'd1, id: id});
            exp_drop++;
        end
        step();
        desc_valid = 1'b0;
    endtask

    task automatic waitCmdValid(input string tag);
        int waited = 0;
        while (cmd_valid !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        checkOutput(tag, cmd_valid, 1'b1);
    endtask

    // Abort the offered command and measure the cmd_valid-low gap
    task automatic measureBackoff(input string tag, input logic [15:0] addr, input logic [15:0] len);
        int   gap = 0;
        logic stable = 1'b1;
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        while (cmd_valid !== 1'b1 && gap < 30) begin
            if (cmd_addr !== addr || cmd_len !== len) stable = 1'b0;
            step();
            gap++;
        end
        checkOutput({tag, "_gap"}, gap, 8);
        checkOutput({tag, "_stable"}, stable, 1'b1);
    endtask

    // Scoreboard monitor: compare every command handshake and error pulse
    always @(negedge AXI_ACLK) begin
        if (AXI_ARESET === 1'b0) begin
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                hs_cycles.push_back(cyc);
                checkOutput("cmd_expected", exp_cmd.size() != 0, 1'b1);
                if (exp_cmd.size() != 0) begin
                    mon_cmd = exp_cmd.pop_front();
                    checkOutput("cmd_fields", {cmd_addr, cmd_id, cmd_burst, cmd_size, cmd_len}, mon_cmd);
                end
            end
            if (err_valid === 1'b1) begin
                checkOutput("err_expected", exp_err.size() != 0, 1'b1);
                if (exp_err.size() != 0) begin
                    mon_err = exp_err.pop_front();
                    checkOutput("err_code_id", {err_code, err_id}, mon_err);
                end
            end
        end
    end

    initial begin
        AXI_ARESET = 1'b1;
        desc_valid = 1'b0;
        desc_addr  = '0;
        desc_id    = '0;
        desc_burst = '0;
        desc_size  = '0;
        desc_len   = '0;
        cmd_ready  = 1'b0;
        cmd_abort  = 1'b0;
        step();
        step();

        // Reset state
        checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
        checkOutput("rst_cmd_fields", {cmd_addr, cmd_id, cmd_burst, cmd_size, cmd_len}, 0);
        checkOutput("rst_desc_ready", desc_ready, 1'b1);
        checkOutput("rst_err", {err_valid, err_code, err_id}, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        AXI_ARESET = 1'b0;
        step();

        // Single legal descriptor with cmd_ready held high
        $display("[TB] single descriptor");
        cmd_ready = 1'b1;
        applyStimulus(16'h00FF, 2'd0, 2'd1, 3'd2, 16'd1052);
        checkOutput("s1_level_after_push", level, 1);
        checkOutput("s1_valid_not_yet", cmd_valid, 1'b0);
        step();
        checkOutput("s1_valid", cmd_valid, 1'b1);
        checkOutput("s1_addr", cmd_addr, 16'h00FF);
        checkOutput("s1_len", cmd_len, 16'd1052);
        step();
        checkOutput("s1_valid_after_accept", cmd_valid, 1'b0);
        checkOutput("s1_level_after_pop", level, 0);

        // Fill the FIFO, then drain in order
        $display("[TB] fill and drain");
        cmd_ready = 1'b0;
        applyStimulus(16'h0100, 2'd0, 2'd1, 3'd2, 16'd16);
        applyStimulus(16'h0200, 2'd1, 2'd1, 3'd1, 16'd32);
        applyStimulus(16'h0300, 2'd2, 2'd0, 3'd0, 16'd1);
        applyStimulus(16'h0400, 2'd3, 2'd2, 3'd2, 16'd64);
        checkOutput("s2_level_full", level, 4);
        checkOutput("s2_desc_ready_full", desc_ready, 1'b0);
        desc_addr  = 16'h0500;
        desc_id    = 2'd0;
        desc_burst = 2'd1;
        desc_size  = 3'd2;
        desc_len   = 16'd8;
        desc_valid = 1'b1;
        step();
        checkOutput("s2_no_accept_full", level, 4);
        hs_cycles.delete();
        cmd_ready = 1'b1;
        applyStimulus(16'h0500, 2'd0, 2'd1, 3'd2, 16'd8);
        for (int i = 0; i < 40 && exp_cmd.size() != 0; i++) step();
        checkOutput("s2_drained", exp_cmd.size(), 0);
        checkOutput("s2_level_empty", level, 0);
        checkOutput("s2_handshakes", hs_cycles.size(), 5);
        for (int i = 1; i < hs_cycles.size(); i++) begin
            checkOutput("s2_spacing", hs_cycles[i] - hs_cycles[i-1], 2);
        end

        // Illegal descriptors are consumed and reported
        $display("[TB] illegal descriptors");
        applyStimulus(16'h0600, 2'd1, 2'd1, 3'd2, 16'd0);
        applyStimulus(16'h0700, 2'd2, 2'd3, 3'd2, 16'd4);
        applyStimulus(16'h0800, 2'd3, 2'd1, 3'd3, 16'd4);
        step();
        step();
        checkOutput("s3_drop_cnt", drop_cnt, exp_drop);
        checkOutput("s3_cmd_valid", cmd_valid, 1'b0);
        checkOutput("s3_level", level, 0);

        // Two aborts then accept
        $display("[TB] abort twice then accept");
        cmd_ready = 1'b0;
        applyStimulus(16'h1234, 2'd1, 2'd1, 3'd2, 16'd64);
        waitCmdValid("s4_first_issue");
        measureBackoff("s4_abort1", 16'h1234, 16'd64);
        measureBackoff("s4_abort2", 16'h1234, 16'd64);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        checkOutput("s4_valid_after_accept", cmd_valid, 1'b0);
        checkOutput("s4_drop_cnt", drop_cnt, exp_drop);

        // Retries exhausted, colliding with an illegal descriptor
        $display("[TB] retry exhaustion");
        applyStimulus(16'h2000, 2'd2, 2'd0, 3'd1, 16'd16);
        applyStimulus(16'h3000, 2'd3, 2'd2, 3'd0, 16'd8);
        for (int k = 0; k < 3; k++) begin
            waitCmdValid("s5_retry_issue");
            cmd_abort = 1'b1;
            step();
            cmd_abort = 1'b0;
        end
        waitCmdValid("s5_last_issue");
        checkOutput("s5_drop_before", drop_cnt, exp_drop);
        cmd_abort  = 1'b1;
        desc_addr  = 16'h4000;
        desc_id    = 2'd1;
        desc_burst = 2'd1;
        desc_size  = 3'd2;
        desc_len   = 16'd0;
        desc_valid = 1'b1;
        exp_err.push_back('{code: 2'd2, id: 2'd2});
        exp_err.push_back('{code: 2'd1, id: 2'd1});
        void'(exp_cmd.pop_front());
        exp_drop += 2;
        step();
        cmd_abort  = 1'b0;
        desc_valid = 1'b0;
        checkOutput("s5_desc_ready_pending", desc_ready, 1'b0);
        checkOutput("s5_drop_cnt", drop_cnt, exp_drop);
        checkOutput("s5_valid_dropped", cmd_valid, 1'b0);
        step();
        checkOutput("s5_desc_ready_free", desc_ready, 1'b1);
        checkOutput("s5_next_issue", {cmd_valid, cmd_id}, {1'b1, 2'd3});
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        checkOutput("err_sb_drained", exp_err.size(), 0);

        // Reset while backing off with entries queued
        $display("[TB] reset during backoff");
        applyStimulus(16'h5000, 2'd0, 2'd1, 3'd2, 16'd4);
        applyStimulus(16'h5100, 2'd1, 2'd1, 3'd2, 16'd4);
        applyStimulus(16'h5200, 2'd2, 2'd1, 3'd2, 16'd4);
        waitCmdValid("s6_issue");
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        step();
        checkOutput("s6_level_pre", level, 3);
        checkOutput("s6_backoff_valid", cmd_valid, 1'b0);
        AXI_ARESET = 1'b1;
        step();
        exp_cmd.delete();
        exp_drop = 0;
        checkOutput("s6_cmd_valid", cmd_valid, 1'b0);
        checkOutput("s6_level", level, 0);
        checkOutput("s6_desc_ready", desc_ready, 1'b1);
        checkOutput("s6_drop_cnt", drop_cnt, exp_drop);
        checkOutput("s6_err_valid", err_valid, 1'b0);
        AXI_ARESET = 1'b0;
        step();
        step();
        checkOutput("s6_stays_idle", cmd_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
